// File: rtl/hook_pkg.sv
// hook_pkg: mode encodings, state enum and default hook depth bounds for hook_ctrl.
package hook_pkg;
  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_HOOK = 2'd1;
  localparam logic [1:0] MODE_BAIT = 2'd2;
  localparam int V_MIN_DEF = 620;
  localparam int V_MAX_DEF = 4600;
  typedef enum logic [1:0] {EMPTY, HOOK, BAITED, REEL} state_t;
endpackage

// File: rtl/sat_accum.sv
// sat_accum: 14-bit value plus signed 15-bit delta, clamped to [LO, HI].
module sat_accum #(
  parameter int LO = 620,
  parameter int HI = 4600
) (
  input  logic [13:0]        val,
  input  logic signed [14:0] delta,
  output logic [13:0]        res
);
  localparam logic signed [14:0] LO_S = 15'(LO);
  localparam logic signed [14:0] HI_S = 15'(HI);
  logic signed [14:0] sum;
  assign sum = $signed({1'b0, val}) + delta;
  assign res = (sum < LO_S) ? 14'(LO) : (sum > HI_S) ? 14'(HI) : sum[13:0];
endmodule

// File: rtl/hook_ctrl.sv
// hook_ctrl: fishing hook/bait FSM with mouse depth control and reeling; HOOK_BAIT_TIMEOUT_EN adds bait loss.
module hook_ctrl
  import hook_pkg::*;
#(
  parameter int V_MIN        = V_MIN_DEF,
  parameter int V_MAX        = V_MAX_DEF,
  parameter int REEL_STEP    = 40,
  parameter int BAIT_TIMEOUT = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        mouse_valid,
  input  logic [8:0]  mouse_dy,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        fish_caught,
  output logic [1:0]  mode,
  output logic [13:0] mouse_v,
  output logic        reeling
);
  localparam logic [13:0] VMIN14 = 14'(V_MIN);
  state_t state, state_n;
  logic [1:0] mode_n;
  logic [13:0] v_n, v_acc;
  logic signed [14:0] delta;
  logic expire;
  assign delta = (state == REEL) ? -$signed(15'(REEL_STEP)) : $signed({{6{mouse_dy[8]}}, mouse_dy});
  sat_accum #(.LO(V_MIN), .HI(V_MAX)) u_acc (.val(mouse_v), .delta(delta), .res(v_acc));
`ifdef HOOK_BAIT_TIMEOUT_EN
  logic [9:0] cnt;
  logic deep;
  assign deep = (state == BAITED) && (mouse_v > VMIN14);
  assign expire = deep && frame_tick && (cnt == 10'(BAIT_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!deep || expire) ? '0 : frame_tick ? cnt + 10'd1 : cnt;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_n = state;
    mode_n = mode;
    v_n = mouse_v;
    case (state)
      EMPTY: if (btn_left) begin
        state_n = HOOK;
        mode_n = MODE_HOOK;
      end
      HOOK, BAITED:
        if (fish_caught && state == BAITED) begin
          state_n = REEL;
          mode_n = MODE_HOOK;
        end else if (btn_right) state_n = REEL;
        else if (btn_left && state == HOOK && mouse_v == VMIN14) begin
          state_n = BAITED;
          mode_n = MODE_BAIT;
        end else if (expire) begin
          state_n = HOOK;
          mode_n = MODE_HOOK;
        end else if (mouse_valid) v_n = v_acc;
      REEL: if (frame_tick) begin
        if (mouse_v == VMIN14) state_n = (mode == MODE_HOOK) ? HOOK : BAITED;
        else v_n = v_acc;
      end
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      mode <= MODE_NONE;
      mouse_v <= VMIN14;
      reeling <= 1'b0;
    end else begin
      state <= state_n;
      mode <= mode_n;
      mouse_v <= v_n;
      reeling <= (state_n == REEL);
    end
endmodule

// File: tb/tb_hook_ctrl.sv
// tb_hook_ctrl: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_hook_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0, mouse_valid = 1'b0, btn_left = 1'b0, btn_right = 1'b0, fish_caught = 1'b0;
  logic [8:0] mouse_dy = '0;
  logic [1:0] mode;
  logic [13:0] mouse_v;
  logic reeling;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string name;
    logic [1:0] m;
    logic [13:0] v;
    logic r;
  } exp_t;
  exp_t q[$];
  exp_t e;

  hook_ctrl #(.BAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mouse_valid(mouse_valid),
    .mouse_dy(mouse_dy), .btn_left(btn_left), .btn_right(btn_right),
    .fish_caught(fish_caught), .mode(mode), .mouse_v(mouse_v), .reeling(reeling)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({mode, mouse_v, reeling} !== {e.m, e.v, e.r}) begin
        errors++;
        $display("FAIL %s: got mode=%0d v=%0d reel=%0d want mode=%0d v=%0d reel=%0d",
                 e.name, mode, mouse_v, reeling, e.m, e.v, e.r);
      end
    end
  end

  task automatic expect_out(input string n, input int m, input int v, input logic r);
    exp_t x;
    x.name = n;
    x.m = 2'(m);
    x.v = 14'(v);
    x.r = r;
    q.push_back(x);
  endtask

  task automatic pulse(input logic l, input logic rt, input logic fc, input logic mv, input logic ft, input logic [8:0] dy);
    @(negedge clk);
    btn_left = l; btn_right = rt; fish_caught = fc; mouse_valid = mv; frame_tick = ft; mouse_dy = dy;
    @(negedge clk);
    btn_left = 0; btn_right = 0; fish_caught = 0; mouse_valid = 0; frame_tick = 0; mouse_dy = '0;
  endtask

  task automatic left();  pulse(1, 0, 0, 0, 0, '0); endtask
  task automatic right(); pulse(0, 1, 0, 0, 0, '0); endtask
  task automatic tick();  pulse(0, 0, 0, 0, 1, '0); endtask
  task automatic move(input logic [8:0] dy); pulse(0, 0, 0, 1, 0, dy); endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 620, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_out("post_reset_idle", 0, 620, 0);
    move(9'd100);
    tick();
    expect_out("empty_ignores_mouse", 0, 620, 0);
    left();
    expect_out("empty_to_hook", 1, 620, 0);
    left();
    expect_out("hook_to_baited", 2, 620, 0);
    checks++;
    if (mode !== 2'd2) begin
      errors++;
      $display("FAIL inline_baited: mode=%0d", mode);
    end
    move(9'd255);
    expect_out("move_first", 2, 875, 0);
    for (int i = 0; i < 19; i++) move(9'd255);
    expect_out("sat_max", 2, 4600, 0);
    move(9'h100);
    expect_out("move_neg", 2, 4344, 0);
    for (int i = 0; i < 19; i++) move(9'h100);
    expect_out("sat_min", 2, 620, 0);
    move(9'd255);
    move(9'd125);
    expect_out("depth_1000", 2, 1000, 0);
    right();
    expect_out("reel_entry", 2, 1000, 1);
    pulse(1, 1, 0, 1, 0, 9'd100);
    expect_out("reel_ignores_inputs", 2, 1000, 1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_out($sformatf("reel_step_%0d", i), 2, (1000 - 40 * i < 620) ? 620 : 1000 - 40 * i, 1);
    end
    tick();
    expect_out("reel_back_baited", 2, 620, 0);
    checks++;
    if (reeling !== 1'b0 || mode !== 2'd2) begin
      errors++;
      $display("FAIL inline_reel_done: mode=%0d reel=%0d", mode, reeling);
    end
    for (int i = 0; i < 5; i++) move(9'd255);
    move(9'd105);
    expect_out("depth_2000", 2, 2000, 0);
    pulse(0, 1, 1, 0, 0, '0);
    expect_out("fish_and_right", 1, 2000, 1);
    tick();
    expect_out("fish_reel_1", 1, 1960, 1);
    for (int i = 0; i < 34; i++) tick();
    expect_out("fish_reel_top", 1, 620, 1);
    tick();
    expect_out("fish_end_hook", 1, 620, 0);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL inline_fish_hook: mode=%0d", mode);
    end
    pulse(0, 0, 1, 0, 0, '0);
    expect_out("hook_ignores_fish", 1, 620, 0);
    move(9'd100);
    left();
    expect_out("hook_left_below_top", 1, 720, 0);
    move(9'h100);
    left();
    expect_out("rebait", 2, 620, 0);
    for (int i = 0; i < 3; i++) move(9'd255);
    move(9'd115);
    right();
    expect_out("reel_at_1500", 2, 1500, 1);
    @(negedge clk);
    rst_n = 1'b0;
    expect_out("async_reset", 0, 620, 0);
    pulse(1, 0, 0, 0, 1, '0);
    expect_out("held_in_reset", 0, 620, 0);
    @(negedge clk);
    rst_n = 1'b1;
    left();
    left();
    move(9'd180);
    expect_out("depth_800", 2, 800, 0);
    for (int i = 0; i < 4; i++) tick();
`ifdef HOOK_BAIT_TIMEOUT_EN
    expect_out("bait_timeout", 1, 800, 0);
`else
    expect_out("bait_persists", 2, 800, 0);
`endif
    repeat (3) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0) $display("FAIL");
    else $display("PASS");
    $finish;
  end
endmodule
